// File: rtl/cache_lru_tracker_if.sv
// Lookup, access-commit and flush signals between the cache way-select logic
// and the LRU tracker. The master side is the cache; the slave side is the tracker.
interface cache_lru_tracker_if #(
   parameter int WAYS       = 4,
   parameter int TOTAL_SIZE = 16
);
   localparam int SW = $clog2(TOTAL_SIZE / WAYS);
   localparam int AW = $clog2(WAYS);

   logic [SW-1:0] lookup_set;
   logic [AW-1:0] lru_way;
   logic          access_valid;
   logic          access_ready;
   logic [SW-1:0] access_set;
   logic [AW-1:0] access_way;
   logic          flush_req;
   logic          flush_busy;
   logic          flush_done;

   modport master (
      output lookup_set, access_valid, access_set, access_way, flush_req,
      input  lru_way, access_ready, flush_busy, flush_done
   );

   modport slave (
      input  lookup_set, access_valid, access_set, access_way, flush_req,
      output lru_way, access_ready, flush_busy, flush_done
   );
endinterface

// File: rtl/cache_lru_tracker.sv
// True-LRU age tracker per cache set: ages form a permutation of 0..WAYS-1
// (0 = MRU). Includes a one-set-per-cycle flush sweep back to reset order.
module cache_lru_tracker #(
   parameter int WAYS       = 4,
   parameter int TOTAL_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cache_lru_tracker_if.slave   bus
);
   localparam int SETS = TOTAL_SIZE / WAYS;
   localparam int SW   = $clog2(SETS);
   localparam int AW   = $clog2(WAYS);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t        r_state;
   logic [SW-1:0] r_idx;
   logic          r_ready;
   logic          r_busy;
   logic          r_done;
   logic [AW-1:0] r_age [SETS][WAYS];

   logic [AW-1:0] w_lru;
   logic [AW-1:0] w_acc_age;

   always_comb begin
      w_lru = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_age[bus.lookup_set][w] == AW'(WAYS - 1)) w_lru = AW'(w);
      end
   end

   assign w_acc_age = r_age[bus.access_set][bus.access_way];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) r_age[s][w] <= AW'(w);
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               // Ways younger than the touched one age by one; older ways keep their age.
               if (bus.access_valid) begin
                  for (int w = 0; w < WAYS; w++) begin
                     if (AW'(w) == bus.access_way)
                        r_age[bus.access_set][w] <= '0;
                     else if (r_age[bus.access_set][w] < w_acc_age)
                        r_age[bus.access_set][w] <= r_age[bus.access_set][w] + AW'(1);
                  end
               end
               if (bus.flush_req) begin
                  r_state <= FLUSH;
                  r_idx   <= '0;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            FLUSH: begin
               for (int w = 0; w < WAYS; w++) r_age[r_idx][w] <= AW'(w);
               r_idx <= r_idx + SW'(1);
               if (r_idx == SW'(SETS - 1)) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.lru_way      = w_lru;
   assign bus.access_ready = r_ready;
   assign bus.flush_busy   = r_busy;
   assign bus.flush_done   = r_done;
endmodule

// File: tb/tb_cache_lru_tracker.sv
// Bench for cache_lru_tracker: a recency-list model (MRU first) per set is
// compared with the DUT every cycle, plus directed literal checks.
module tb_cache_lru_tracker;
   localparam int WAYS       = 4;
   localparam int TOTAL_SIZE = 16;
   localparam int SETS       = TOTAL_SIZE / WAYS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_lru_tracker_if #(.WAYS(WAYS), .TOTAL_SIZE(TOTAL_SIZE)) bus ();

   cache_lru_tracker #(.WAYS(WAYS), .TOTAL_SIZE(TOTAL_SIZE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;
   int done_cnt = 0;
   int busy_cnt = 0;

   // Model: ord[s][0] is the most recently used way, ord[s][WAYS-1] the LRU way.
   int ord [SETS][WAYS];
   bit m_busy = 1'b0;
   bit m_done = 1'b0;
   int m_idx  = 0;

   function automatic void m_reset_set(int s);
      for (int i = 0; i < WAYS; i++) ord[s][i] = i;
   endfunction

   function automatic int m_lru(int s);
      return ord[s][WAYS-1];
   endfunction

   function automatic void m_touch(int s, int w);
      int p = 0;
      for (int i = 0; i < WAYS; i++) if (ord[s][i] == w) p = i;
      for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
      ord[s][0] = w;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) m_reset_set(s);
         m_busy = 1'b0;
         m_done = 1'b0;
         m_idx  = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            m_reset_set(m_idx);
            if (m_idx == SETS - 1) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
            m_idx++;
         end else begin
            if (bus.access_valid) m_touch(int'(bus.access_set), int'(bus.access_way));
            if (bus.flush_req) begin
               m_busy = 1'b1;
               m_idx  = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("lru_way", bus.lru_way, m_lru(int'(bus.lookup_set)));
         check("access_ready", bus.access_ready, !m_busy);
         check("flush_busy", bus.flush_busy, m_busy);
         check("flush_done", bus.flush_done, m_done);
         if (bus.flush_done === 1'b1) done_cnt++;
         if (bus.flush_busy === 1'b1) busy_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic access(int s, int w);
      bus.access_valid = 1'b1;
      bus.access_set   = s[1:0];
      bus.access_way   = w[1:0];
      tick();
      bus.access_valid = 1'b0;
   endtask

   task automatic look(int s, int exp, string name);
      bus.lookup_set = s[1:0];
      @(negedge clk);
      check(name, bus.lru_way, exp);
      tick();
   endtask

   task automatic dirty_all();
      for (int s = 0; s < SETS; s++) begin
         access(s, 3);
         access(s, $urandom_range(0, WAYS - 1));
      end
   endtask

   initial begin
      bus.lookup_set   = '0;
      bus.access_valid = 1'b0;
      bus.access_set   = '0;
      bus.access_way   = '0;
      bus.flush_req    = 1'b0;
      for (int s = 0; s < SETS; s++) m_reset_set(s);
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Reset order
      for (int s = 0; s < SETS; s++) look(s, 3, "t1_reset_lru");
      @(negedge clk);
      check("t1_ready", bus.access_ready, 1);
      check("t1_busy", bus.flush_busy, 0);
      tick();

      // Full rotation, then one more access
      access(1, 3); access(1, 2); access(1, 1); access(1, 0);
      look(1, 3, "t2_rotate_lru");
      access(1, 3);
      look(1, 2, "t2_after_way3");
      look(0, 3, "t2_set0_untouched");

      // Repeated MRU access
      access(2, 1); access(2, 1);
      look(2, 3, "t3_lru");
      check("t3_model_mru", ord[2][0], 1);
      check("t3_model_2nd", ord[2][1], 0);

      // Same-cycle access and lookup
      bus.lookup_set   = 2'd0;
      bus.access_valid = 1'b1;
      bus.access_set   = 2'd0;
      bus.access_way   = 2'd3;
      @(negedge clk);
      check("t4_pre_update", bus.lru_way, 3);
      tick();
      bus.access_valid = 1'b0;
      @(negedge clk);
      check("t4_post_update", bus.lru_way, 2);
      tick();

      // Flush with a dropped access
      dirty_all();
      busy_cnt = 0;
      done_cnt = 0;
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      access(0, 3);
      repeat (6) tick();
      check("t5_busy_cycles", busy_cnt, 4);
      check("t5_done_pulses", done_cnt, 1);
      for (int s = 0; s < SETS; s++) look(s, 3, "t5_flushed_lru");

      // Reset in the middle of a flush
      dirty_all();
      done_cnt = 0;
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_busy_after_rst", bus.flush_busy, 0);
      tick();
      repeat (5) tick();
      check("t6_no_done", done_cnt, 0);
      for (int s = 0; s < SETS; s++) look(s, 3, "t6_reset_lru");

      // Randomized traffic, including flush requests mid-stream
      for (int i = 0; i < 400; i++) begin
         bus.lookup_set   = 2'($urandom_range(0, SETS - 1));
         bus.access_valid = 1'($urandom_range(0, 1));
         bus.access_set   = 2'($urandom_range(0, SETS - 1));
         bus.access_way   = 2'($urandom_range(0, WAYS - 1));
         bus.flush_req    = ($urandom_range(0, 39) == 0);
         tick();
      end
      bus.access_valid = 1'b0;
      bus.flush_req    = 1'b0;
      repeat (8) tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
